// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : clkdiv_pkg
// Description : Shared constants for the multi-channel frequency divider.
//               MODE_*       : per-channel output mode encoding
//               DEFAULT_CNT_W: default counter / half-period width
//               HALF_10KHZ   : exact half-period for 10 kHz from a 50 MHz clock
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

  // Output mode encoding (one bit per channel on the mode bus)
  localparam logic MODE_TOGGLE = 1'b0;  // 50% duty square wave
  localparam logic MODE_PULSE  = 1'b1;  // one-cycle high per period

  localparam int DEFAULT_CNT_W = 32;

  // 50 MHz / (2 * (2499 + 1)) = 10 kHz exactly. The legacy reset value 2500
  // gives ~9.996 kHz and is kept so existing consumers see no change.
  localparam int HALF_10KHZ = 2499;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/multi_freq_divider_if.sv
`default_nettype none
// ============================================================================
// Interface   : multi_freq_divider_if
// Description : Control / configuration / output bundle of the divider.
//   en[NUM_CH]       per-channel run enable
//   restart[NUM_CH]  per-channel synchronous phase restart
//   mode[NUM_CH]     0 = toggle, 1 = pulse
//   cfg_we           half-period write strobe
//   cfg_ch[CH_W]     target channel of the write
//   cfg_half[CNT_W]  new half-period value
//   div_clk[NUM_CH]  registered divided outputs
//   tick[NUM_CH]     registered one-cycle wrap strobes
//   master: drives controls, receives outputs. slave: the divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface multi_freq_divider_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 2
);
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] restart;
  logic [NUM_CH-1:0] mode;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] div_clk;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, restart, mode, cfg_we, cfg_ch, cfg_half,
    input  div_clk, tick
  );

  modport slave (
    input  en, restart, mode, cfg_we, cfg_ch, cfg_half,
    output div_clk, tick
  );
endinterface : multi_freq_divider_if
`default_nettype wire

// File: rtl/clkdiv_channel.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_channel
// Description : One divider channel: wrap counter, active/shadow half-period
//               registers and toggle/pulse output logic. All outputs are
//               registered.
//   clk, rst     system clock, synchronous active-high reset
//   en_i         run enable (0 freezes count and div_clk)
//   restart_i    synchronous phase restart
//   mode_i       MODE_TOGGLE / MODE_PULSE
//   cfg_we_i     write strobe already decoded for this channel
//   cfg_half_i   new half-period value
//   div_clk_o    divided output
//   tick_o       one-cycle strobe on counter wrap
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               CNT_W        = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(2500)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             en_i,
  input  wire logic             restart_i,
  input  wire logic             mode_i,
  input  wire logic             cfg_we_i,
  input  wire logic [CNT_W-1:0] cfg_half_i,
  output logic                  div_clk_o,
  output logic                  tick_o
);

  logic [CNT_W-1:0] count_q,  count_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             div_q,    div_d;
  logic             tick_q,   tick_d;

  logic [CNT_W-1:0] w_next_half;
  logic             w_wrap;

  // A write landing in the same cycle as a wrap/restart is bypassed so the
  // new ratio takes effect immediately instead of one period later.
  assign w_next_half = cfg_we_i ? cfg_half_i : shadow_q;

  // active_q only changes while count_q is 0, so count_q never passes it and
  // equality is a sufficient wrap test.
  assign w_wrap = (count_q == active_q);

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    shadow_d = w_next_half;
    div_d    = div_q;
    tick_d   = 1'b0;
    if (restart_i) begin
      count_d  = '0;
      div_d    = 1'b0;
      active_d = w_next_half;
    end else if (en_i) begin
      if (w_wrap) begin
        count_d  = '0;
        tick_d   = 1'b1;
        active_d = w_next_half;
        div_d    = (mode_i == MODE_PULSE) ? 1'b1 : ~div_q;
      end else begin
        count_d = count_q + CNT_W'(1);
        // Pulse mode follows tick; toggle mode holds between wraps, which
        // also gives the pulse->toggle "hold until next wrap" behaviour.
        div_d   = (mode_i == MODE_PULSE) ? 1'b0 : div_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      active_q <= DEFAULT_HALF;
      shadow_q <= DEFAULT_HALF;
      div_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
    end
  end

  assign div_clk_o = div_q;
  assign tick_o    = tick_q;

endmodule : clkdiv_channel
`default_nettype wire

// File: rtl/multi_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : multi_freq_divider
// Description : NUM_CH independent runtime-programmable clock dividers sharing
//               one system clock. Decodes the configuration write into
//               per-channel strobes; out-of-range channel writes are dropped.
//   clk, rst  system clock, synchronous active-high reset
//   bus       multi_freq_divider_if.slave (controls in, div_clk/tick out)
// Revision    : 1.0 - initial release
// ============================================================================
module multi_freq_divider
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = DEFAULT_CNT_W,
  parameter int DEFAULT_HALF = 2500,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input wire logic            clk,
  input wire logic            rst,
  multi_freq_divider_if.slave bus
);

  logic              w_cfg_in_range;
  logic [NUM_CH-1:0] w_div;
  logic [NUM_CH-1:0] w_tick;

  // CH_W may be wider than needed, so range-check before decoding.
  assign w_cfg_in_range = bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_we;
    assign w_we = w_cfg_in_range && (bus.cfg_ch == CH_W'(i));

    clkdiv_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (CNT_W'(DEFAULT_HALF))
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_i       (bus.en[i]),
      .restart_i  (bus.restart[i]),
      .mode_i     (bus.mode[i]),
      .cfg_we_i   (w_we),
      .cfg_half_i (bus.cfg_half),
      .div_clk_o  (w_div[i]),
      .tick_o     (w_tick[i])
    );
  end

  assign bus.div_clk = w_div;
  assign bus.tick    = w_tick;

endmodule : multi_freq_divider
`default_nettype wire

// File: tb/tb_multi_freq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_freq_divider
// Description : Scoreboard bench for multi_freq_divider. A reference model
//               tracks "cycles remaining until the next tick" per channel and
//               pushes the expected div_clk/tick after every edge; a monitor
//               pops and compares after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_freq_divider;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int CH_W   = 3;   // wide enough to address channels 4..7
  localparam int DEF_H  = 2500;

  typedef struct packed {
    logic [NUM_CH-1:0] div;
    logic [NUM_CH-1:0] tick;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  multi_freq_divider_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

  multi_freq_divider #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_HALF(DEF_H), .CH_W(CH_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Reference model: cycles left until the next wrap, plus the pending ratio.
  int unsigned m_remain[NUM_CH];
  int unsigned m_shadow[NUM_CH];
  bit          m_div[NUM_CH];
  bit          m_tick[NUM_CH];

  task automatic model_step();
    exp_t e;
    int unsigned nh;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_remain[i] = DEF_H;
        m_shadow[i] = DEF_H;
        m_div[i]    = 1'b0;
        m_tick[i]   = 1'b0;
      end else begin
        nh = (bus.cfg_we && int'(bus.cfg_ch) == i) ? bus.cfg_half : m_shadow[i];
        m_shadow[i] = nh;
        m_tick[i]   = 1'b0;
        if (bus.restart[i]) begin
          m_remain[i] = nh;
          m_div[i]    = 1'b0;
        end else if (bus.en[i]) begin
          if (m_remain[i] == 0) begin
            m_tick[i]   = 1'b1;
            m_remain[i] = nh;
            m_div[i]    = bus.mode[i] ? 1'b1 : ~m_div[i];
          end else begin
            m_remain[i] = m_remain[i] - 1;
            if (bus.mode[i]) m_div[i] = 1'b0;
          end
        end
      end
      e.div[i]  = m_div[i];
      e.tick[i] = m_tick[i];
    end
    exp_q.push_back(e);
  endtask

  // Inputs are applied on the falling edge; the model predicts the state
  // the DUT will present after the following rising edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.en[i]      = ($urandom_range(0, 9) != 0);
      bus.restart[i] = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) bus.mode[i] = ~bus.mode[i];
    end
    bus.cfg_we   = ($urandom_range(0, 7) == 0);
    bus.cfg_ch   = CH_W'($urandom_range(0, 7));
    bus.cfg_half = CNT_W'($urandom_range(0, 7));
  endtask

  // Monitor
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NUM_CH; i++) begin
          checks++;
          if (bus.div_clk[i] !== e.div[i]) begin
            errors++;
            $display("FAIL div_clk[%0d] t=%0t got %b expected %b", i, $time, bus.div_clk[i], e.div[i]);
          end
          checks++;
          if (bus.tick[i] !== e.tick[i]) begin
            errors++;
            $display("FAIL tick[%0d] t=%0t got %b expected %b", i, $time, bus.tick[i], e.tick[i]);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst          = 1'b1;
    bus.en       = '1;
    bus.restart  = '0;
    bus.mode     = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_half = '0;

    repeat (3) begin @(negedge clk); cycle(); end
    @(negedge clk);
    rst = 1'b0;

    // Default ratio, all toggle: first rise after 2501 edges, period 5002.
    repeat (5200) begin cycle(); @(negedge clk); end

    // Randomized control, short ratios, out-of-range channel writes.
    repeat (5000) begin randomize_inputs(); cycle(); @(negedge clk); end

    // Reset mid-run with inputs active.
    rst = 1'b1;
    randomize_inputs();
    cycle();
    @(negedge clk);
    rst = 1'b0;
    repeat (2500) begin randomize_inputs(); cycle(); @(negedge clk); end

    // Let the monitor drain, bounded.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multi_freq_divider
`default_nettype wire

// File: doc/multi_freq_divider.md
Name: multi_freq_divider

Overview:
- Parametrised, multi-channel successor to the team's fixed-ratio frequency divider.
- Each channel divides the single system clock by a runtime-programmable ratio.
- Each channel drives a registered divided output plus a one-cycle tick strobe.
- Feeds display scan (dot matrix, 7-seg mux), debouncers and timers from one shared block instead of one hard-coded divider per consumer.

Parameters:
- NUM_CH, 4: number of independent divider channels (1..16).
- CNT_W, 32: width of each channel's counter and half-period value.
- DEFAULT_HALF, 2500: half-period loaded into every channel's active and shadow registers at reset.
- CH_W, $clog2(NUM_CH) (min 1): width of the channel-select field.

Ports:
- clk  in  1  system clock (50 MHz on board).
- rst  in  1  synchronous reset, active-high.
- en  in  NUM_CH  per-channel run enable; 0 freezes that channel.
- restart  in  NUM_CH  per-channel synchronous phase restart.
- mode  in  NUM_CH  0 = toggle (50% duty square wave), 1 = pulse (one-cycle high per period).
- cfg_we  in  1  write strobe for half-period configuration.
- cfg_ch  in  CH_W  target channel for cfg_we.
- cfg_half  in  CNT_W  new half-period value H.
- div_clk  out  NUM_CH  divided output, registered.
- tick  out  NUM_CH  one-cycle strobe on every counter wrap, registered.

Behaviour:
- Reset (rst=1 at a clk edge), applied to all channels:
  - count=0, div_clk=0, tick=0.
  - active_half=shadow_half=DEFAULT_HALF.
  - Reset has priority over every other input.
  - Reset mid-period discards the current phase.
- Counting (en[i]=1):
  - count increments by 1 each cycle.
  - Wrap event: count==active_half. On wrap, count<=0 and tick[i]<=1 for exactly one cycle; tick<=0 on all other cycles.
  - Ticks are active_half+1 cycles apart.
- Toggle mode:
  - div_clk inverts on each wrap.
  - Period = 2*(H+1) cycles, exactly 50% duty.
  - H=0 gives div-by-2.
- Pulse mode:
  - div_clk equals tick, i.e. high one cycle per H+1 cycles.
  - H=0 gives div_clk constantly 1.
- Mode change mid-run:
  - Takes effect the next cycle; the counter is not disturbed.
  - Switching toggle->pulse: div_clk drops to 0 on the next non-wrap cycle.
  - Switching pulse->toggle: div_clk holds its current value until the next wrap.
- Disable (en[i]=0):
  - count and div_clk hold; tick=0.
  - Re-enabling resumes from the held count with no glitch.
- Configuration:
  - cfg_we with cfg_ch<NUM_CH writes cfg_half into shadow_half[cfg_ch].
  - cfg_ch>=NUM_CH is ignored; no state changes.
  - active_half<=shadow_half only at a wrap or a restart. A ratio change never truncates or stretches the period in progress.
- Simultaneous cfg_we and wrap on the same channel: the newly written value is bypassed straight into active_half at that wrap.
- Restart (restart[i]=1):
  - count<=0, div_clk<=0, tick<=0, active_half<=shadow_half (with the same cfg_we bypass).
  - Overrides en and wrap; a restart on one channel does not affect the others.
  - Holding restart keeps the channel at phase 0.
- Priority per channel: rst > restart > en/wrap.
- Arithmetic:
  - Unsigned; count is never compared with >, only ==.
  - Because active_half changes only when count==0, count can never exceed active_half.
- Latency: all outputs are registered. tick and div_clk change on the edge where count==active_half is sampled; there is no combinational path from input to output.

Decomposition:
- Package clkdiv_pkg holds:
  - MODE_TOGGLE=1'b0, MODE_PULSE=1'b1.
  - DEFAULT_CNT_W=32.
  - Helper constant for 10 kHz at 50 MHz: HALF_10KHZ=2499 (exact; DEFAULT_HALF=2500 gives ~9.996 kHz, kept for legacy behaviour).
- One sub-module, clkdiv_channel: counter, active/shadow registers, mode logic.
- The top generates NUM_CH instances and decodes cfg_we/cfg_ch into per-channel write enables.

Test Plan:
- Reset release, NUM_CH=4, all en=1, mode=0 -> every div_clk first rises on cycle 2501 and has period 5002 cycles; tick every 2501 cycles.
- Write cfg_ch=1, cfg_half=3 at mid-period (count=1000):
  - Ch1 finishes the current 2501-cycle half.
  - Thereafter ch1 toggles every 4 cycles (period 8).
  - Other channels are unchanged.
- Ch2 mode=1, H=0 -> div_clk[2] constant 1. Then write H=1 -> high one cycle, low one cycle, starting after the next wrap.
- Deassert en[0] at count=10 for 7 cycles -> count and div_clk hold, tick=0. Re-enable -> the next wrap occurs 2491 cycles later.
- cfg_we coincident with ch3 wrap, cfg_half=5 -> the next ch3 tick arrives exactly 6 cycles later. Also: cfg_ch=5 with NUM_CH=4 -> no register changes.
- Corner cases:
  - restart[0] asserted together with a ch0 wrap and a pending shadow value 7 -> div_clk[0]=0, tick[0]=0, next tick after 8 cycles.
  - rst asserted mid-run -> all outputs 0 on the next cycle.
